// File: rtl/multi_display_counter.sv
// multi_display_counter: N debounced press counters, each driving
// its own multiplexed 7-segment display from one shared refresh scan.

module mdc_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic          level_d;
  logic [DW-1:0] cnt;

  // two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

  // accept a new level only after a full stable run; bounce restarts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (s2 == level) begin
      cnt   <= '0;
    end else if (cnt == LAST) begin
      level <= s2;
      cnt   <= '0;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  // previous accepted level, for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_d <= 1'b0;
    else        level_d <= level;
  end

  assign press = level & ~level_d;

endmodule

module multi_display_counter #(
  parameter string MODE            = "HEX",
  parameter int    NUM_SEGMENTS    = 4,
  parameter int    NUM_DISPLAYS    = 2,
  parameter int    CLK_PER         = 10,
  parameter int    REFR_RATE       = 1000,
  parameter int    DEBOUNCE_CYCLES = 500000
) (
  input  logic                                clk,
  input  logic                                CPU_RESETN,
  input  logic [NUM_DISPLAYS-1:0]             BTN,
  input  logic                                BTNU,
  output logic [NUM_DISPLAYS*4*NUM_SEGMENTS-1:0] count,
  output logic [NUM_DISPLAYS*NUM_SEGMENTS-1:0]   anode,
  output logic [NUM_DISPLAYS*8-1:0]           cathode
);

  localparam int CW = 4 * NUM_SEGMENTS;
  localparam int DIGIT_RAW =
    1000000000 / (CLK_PER * REFR_RATE * NUM_SEGMENTS);
  localparam int DIGIT_CYC = (DIGIT_RAW < 1) ? 1 : DIGIT_RAW;
  localparam int SW = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;
  localparam int IW = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;
  localparam bit IS_DEC = (MODE == "DEC");

  if (MODE != "HEX" && MODE != "DEC") begin : g_bad_mode
    $error("multi_display_counter: MODE must be HEX or DEC");
  end

  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_SEGMENTS; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic          clr;
  logic [SW-1:0] scan_q;
  logic [IW-1:0] idx_q;

  mdc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk   (clk),
    .rst_n (CPU_RESETN),
    .pin   (BTNU),
    .press (clr)
  );

  // shared refresh scan: dwell DIGIT_CYC cycles per digit
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == SW'(DIGIT_CYC - 1)) begin
      scan_q <= '0;
      idx_q  <= (idx_q == IW'(NUM_SEGMENTS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  for (genvar d = 0; d < NUM_DISPLAYS; d++) begin : g_ch
    logic                    press;
    logic [CW-1:0]           cnt_q;
    logic [3:0]              nib;
    logic [NUM_SEGMENTS-1:0] an_q;
    logic [7:0]              ca_q;

    mdc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk   (clk),
      .rst_n (CPU_RESETN),
      .pin   (BTN[d]),
      .press (press)
    );

    // press counter; a simultaneous clear takes precedence
    always_ff @(posedge clk or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        cnt_q <= '0;
      end else begin
        unique case (1'b1)
          clr:            cnt_q <= '0;
          press && !clr:  cnt_q <= IS_DEC ? bcd_inc(cnt_q)
                                          : cnt_q + 1'b1;
          default: ;
        endcase
      end
    end

    assign nib = cnt_q[{idx_q, 2'b00} +: 4];

    // registered digit select and segments for the current index
    always_ff @(posedge clk or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        an_q <= '1;
        ca_q <= 8'hFF;
      end else begin
        an_q <= ~(NUM_SEGMENTS'(1) << idx_q);
        ca_q <= seg7(nib);
      end
    end

    assign count[d*CW +: CW]                     = cnt_q;
    assign anode[d*NUM_SEGMENTS +: NUM_SEGMENTS] = an_q;
    assign cathode[d*8 +: 8]                     = ca_q;
  end

endmodule

// File: tb/tb_multi_display_counter.sv
// tb_multi_display_counter: scoreboard bench for a HEX and a DEC
// instance; monitors pop expected counts and scan frames on change.

module tb_multi_display_counter;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  btn = '0;
  logic [1:0]  dbtn = '0;
  logic        btnu = 1'b0;
  logic        dbtnu = 1'b0;
  logic [31:0] count_h;
  logic [31:0] count_d;
  logic [7:0]  anode_h;
  logic [7:0]  anode_d;
  logic [15:0] cath_h;
  logic [15:0] cath_d;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   scan_last = 0;
  bit   skip = 1'b1;
  bit   scan_en = 1'b0;
  exp_t hq[$];
  exp_t dq[$];
  exp_t sq[$];

  multi_display_counter #(
    .MODE("HEX"), .NUM_SEGMENTS(4), .NUM_DISPLAYS(2),
    .CLK_PER(10), .REFR_RATE(3125000), .DEBOUNCE_CYCLES(4)
  ) dut_h (
    .clk(clk), .CPU_RESETN(rst_n), .BTN(btn), .BTNU(btnu),
    .count(count_h), .anode(anode_h), .cathode(cath_h)
  );

  multi_display_counter #(
    .MODE("DEC"), .NUM_SEGMENTS(4), .NUM_DISPLAYS(2),
    .CLK_PER(10), .REFR_RATE(3125000), .DEBOUNCE_CYCLES(4)
  ) dut_d (
    .clk(clk), .CPU_RESETN(rst_n), .BTN(dbtn), .BTNU(dbtnu),
    .count(count_d), .anode(anode_d), .cathode(cath_d)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : mon_hex
    logic [31:0] prev;
    exp_t        e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (skip) begin
        prev = count_h;
      end else if (count_h !== prev) begin
        prev = count_h;
        if (hq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL hex_unexpected: got %h want no change", count_h);
        end else begin
          e = hq.pop_front();
          check("hex_count", count_h, e.val);
          if (e.cyc >= 0) check("hex_latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin : mon_dec
    logic [31:0] prev;
    exp_t        e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (skip) begin
        prev = count_d;
      end else if (count_d !== prev) begin
        prev = count_d;
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dec_unexpected: got %h want no change", count_d);
        end else begin
          e = dq.pop_front();
          check("dec_count", count_d, e.val);
          if (e.cyc >= 0) check("dec_latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin : mon_scan
    logic [7:0] prev;
    exp_t       e;
    prev = '1;
    forever begin
      @(negedge clk);
      if (anode_h !== prev) begin
        prev = anode_h;
        if (scan_en) begin
          if (sq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scan_unexpected: got %h want no change",
                     anode_h);
          end else begin
            e = sq.pop_front();
            check("scan_frame", {8'h00, anode_h, cath_h}, e.val);
            check("scan_period", cyc - scan_last, 32'd8);
          end
        end
        scan_last = cyc;
      end
    end
  end

  task automatic press_h(int ch, logic [31:0] expv);
    hq.push_back('{expv, cyc + 7});
    btn[ch] = 1'b1;
    tick(20);
    btn[ch] = 1'b0;
    tick(10);
  endtask

  task automatic press_d(int ch, logic [31:0] expv);
    dq.push_back('{expv, cyc + 7});
    dbtn[ch] = 1'b1;
    tick(12);
    dbtn[ch] = 1'b0;
    tick(10);
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while ((hq.size() + dq.size() + sq.size()) != 0 && n < 50) begin
      tick(1);
      n++;
    end
    check(name, hq.size() + dq.size() + sq.size(), 32'd0);
  endtask

  initial begin : stim
    bit found;

    // 1: reset held, then first scan frame
    tick(5);
    check("rst_anode_h", anode_h, 8'hFF);
    check("rst_cath_h", cath_h, 16'hFFFF);
    check("rst_anode_d", anode_d, 8'hFF);
    check("rst_count_h", count_h, 32'h0);
    rst_n = 1'b1;
    tick(1);
    check("first_anode", anode_h, 8'hEE);
    check("first_cath", cath_h, 16'hC0C0);
    tick(1);
    skip = 1'b0;

    // 2: clean press on channel 0, held 20 cycles
    press_h(0, 32'h0000_0001);
    drain("drain_press");

    // 3: bouncing channel 1, then held
    for (int i = 0; i < 4; i++) begin
      btn[1] = ~btn[1];
      tick(2);
    end
    hq.push_back('{32'h0001_0001, cyc + 7});
    btn[1] = 1'b1;
    tick(20);
    btn[1] = 1'b0;
    tick(10);
    drain("drain_bounce");

    // 4: HEX wrap from all-Fs
    skip = 1'b1;
    force dut_h.g_ch[0].cnt_q = 16'hFFFF;
    tick(2);
    release dut_h.g_ch[0].cnt_q;
    tick(2);
    skip = 1'b0;
    press_h(0, 32'h0001_0000);

    // 4: DEC carry and wrap
    skip = 1'b1;
    force dut_d.g_ch[0].cnt_q = 16'h0099;
    force dut_d.g_ch[1].cnt_q = 16'h0009;
    tick(2);
    release dut_d.g_ch[0].cnt_q;
    release dut_d.g_ch[1].cnt_q;
    tick(2);
    skip = 1'b0;
    press_d(0, 32'h0009_0100);
    press_d(1, 32'h0010_0100);
    skip = 1'b1;
    force dut_d.g_ch[0].cnt_q = 16'h9999;
    tick(2);
    release dut_d.g_ch[0].cnt_q;
    tick(2);
    skip = 1'b0;
    press_d(0, 32'h0010_0000);
    drain("drain_wrap");

    // 5: clear and press accepted in the same cycle
    hq.push_back('{32'h0000_0000, cyc + 7});
    btn[0] = 1'b1;
    btnu = 1'b1;
    tick(20);
    btn[0] = 1'b0;
    btnu = 1'b0;
    tick(10);
    press_h(0, 32'h0000_0001);
    drain("drain_clear");

    // 6: scan digits of 16'h1234 on display 0
    skip = 1'b1;
    force dut_h.g_ch[0].cnt_q = 16'h1234;
    tick(2);
    release dut_h.g_ch[0].cnt_q;
    tick(2);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      #1;
      if (anode_h == 8'hEE && scan_last == cyc) found = 1'b1;
    end
    check("scan_found", {31'd0, found}, 32'd1);
    check("scan_d0", {8'h00, anode_h, cath_h}, 32'h00EE_C099);
    sq.push_back('{32'h00DD_C0B0, -1});
    sq.push_back('{32'h00BB_C0A4, -1});
    sq.push_back('{32'h0077_C0F9, -1});
    scan_en = 1'b1;
    repeat (26) @(negedge clk);
    #1;
    scan_en = 1'b0;
    drain("drain_scan");

    // asynchronous reset in the middle of a digit
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_anode", anode_h, 8'hFF);
    check("midrst_cath", cath_h, 16'hFFFF);
    check("midrst_count", count_h, 32'h0);
    check("midrst_cath_d", cath_d, 16'hFFFF);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
